// File: rtl/axi_codes_pkg.sv
// Shared AXI write-address definitions: descriptor field layout, FSM encoding
// and the largest legal AxSIZE code.
package axi_codes_pkg;

    localparam int DESC_W    = 97;
    localparam int ADDR_LSB  = 0;
    localparam int ADDR_W    = 64;
    localparam int LEN_LSB   = 64;
    localparam int LEN_W     = 8;
    localparam int SIZE_LSB  = 72;
    localparam int SIZE_W    = 3;
    localparam int BURST_LSB = 75;
    localparam int BURST_W   = 2;
    localparam int ID_LSB    = 77;
    localparam int ID_W      = 8;
    localparam int RSVD_LSB  = 85;
    localparam int RSVD_W    = 12;

    localparam logic [2:0] AXI_MAX_SIZE = 3'd6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    function automatic logic size_legal(input logic [SIZE_W-1:0] size);
        return (size <= AXI_MAX_SIZE);
    endfunction

endpackage

// File: rtl/aw_arbiter.sv
// Source arbiter for the AW channel. AW_ROUND_ROBIN_EN selects round-robin
// (search starts at the pointer, which moves past each grant); otherwise
// fixed priority with source 0 highest.
module aw_arbiter #(
    parameter int NUM_SRC = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_SRC-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);
    import axi_codes_pkg::*;

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

`ifdef AW_ROUND_ROBIN_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

    logic [IDX_W-1:0] r_ptr;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int c;
            c = (int'(r_ptr) + k) % NUM_SRC;
            if (!w_found && i_req[c]) begin
                w_found = 1'b1;
                w_idx   = IDX_W'(c);
            end else begin
                w_idx   = w_idx;
            end
        end
    end

    // Pointer moves to the source after the one just granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (w_idx == LAST_IDX) ? '0 : (w_idx + IDX_W'(1));
        end else begin
            r_ptr <= r_ptr;
        end
    end
`else
    logic w_unused_ok;

    // Lowest-numbered requester wins.
    always_comb begin
        w_found = |i_req;
        w_idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                w_idx = IDX_W'(k);
            end else begin
                w_idx = w_idx;
            end
        end
    end

    assign w_unused_ok = ^{clk, reset_n, i_advance};
`endif

    assign o_idx   = w_idx;
    assign o_grant = w_found ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << w_idx) : '0;

endmodule

// File: rtl/aw_channel.sv
// AXI write-address issue: pops descriptors from per-source FIFOs, drives AW,
// forwards accepted descriptors to the W channel. AW_ROUND_ROBIN_EN selects RR.
module aw_channel #(
    parameter int NUM_SRC         = 8,
    parameter int DESC_W          = 97,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_SRC-1:0]        req_fifo_empty,
    input  logic [NUM_SRC*DESC_W-1:0] req_fifo_rdata,
    output logic [NUM_SRC-1:0]        rd_req_fifo,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [63:0]               awaddr,
    output logic [7:0]                awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic [7:0]                awid,
    input  logic                      axi_conv_fifo_full,
    output logic                      wr_axi_conv_fifo,
    output logic [DESC_W-1:0]         axi_conv_fifo_wrdata,
    input  logic                      bvalid,
    input  logic                      bready,
    output logic                      illegal_size,
    output logic [3:0]                outstanding_cnt
);
    import axi_codes_pkg::*;

    localparam int         IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    logic [1:0]         r_state;
    logic [DESC_W-1:0]  r_desc;
    logic               r_awvalid;
    logic               r_illegal;
    logic [3:0]         r_cnt;
    logic               w_can_grant;
    logic               w_fire;
    logic               w_aw_hs;
    logic               w_b_hs;
    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic [DESC_W-1:0]  w_sel_desc;

    // W-FIFO space is reserved at grant; this block is that FIFO's only writer.
    assign w_can_grant = reset_n && (r_state == ST_IDLE) && !axi_conv_fifo_full
                         && (r_cnt < MAX_CNT);
    assign w_req       = ~req_fifo_empty & {NUM_SRC{w_can_grant}};
    assign w_fire      = |w_grant;
    assign w_aw_hs     = r_awvalid & awready;
    assign w_b_hs      = bvalid & bready & (r_cnt != 4'd0);

    aw_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (w_req),
        .i_advance (w_fire),
        .o_grant   (w_grant),
        .o_idx     (w_idx)
    );

    // Head descriptor of the granted source.
    always_comb begin
        w_sel_desc = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            w_sel_desc = w_sel_desc
                       | (req_fifo_rdata[n*DESC_W +: DESC_W] & {DESC_W{w_idx == IDX_W'(n)}});
        end
    end

    // Issue FSM: capture on grant, hold AW until accepted, or drop bad sizes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_desc    <= '0;
            r_awvalid <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fire) begin
                        r_desc <= w_sel_desc;
                        if (size_legal(w_sel_desc[SIZE_LSB +: SIZE_W])) begin
                            r_state   <= ST_ISSUE;
                            r_awvalid <= 1'b1;
                        end else begin
                            r_state   <= ST_DROP;
                            r_illegal <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (awready) begin
                        r_state   <= ST_IDLE;
                        r_awvalid <= 1'b0;
                    end else begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_DROP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_awvalid <= 1'b0;
                end
            endcase
        end
    end

    // In-flight bursts: up on AW handshake, down on B; stray B beats ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 4'd0;
        end else begin
            case ({w_aw_hs, w_b_hs})
                2'b10: begin
                    if (r_cnt < MAX_CNT) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                2'b01:   r_cnt <= r_cnt - 4'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign rd_req_fifo          = w_grant;
    assign awvalid              = r_awvalid;
    assign awaddr               = r_desc[ADDR_LSB +: ADDR_W];
    assign awlen                = r_desc[LEN_LSB +: LEN_W];
    assign awsize               = r_desc[SIZE_LSB +: SIZE_W];
    assign awburst              = r_desc[BURST_LSB +: BURST_W];
    assign awid                 = r_desc[ID_LSB +: ID_W];
    assign wr_axi_conv_fifo     = w_aw_hs;
    assign axi_conv_fifo_wrdata = r_desc;
    assign illegal_size         = r_illegal;
    assign outstanding_cnt      = r_cnt;

endmodule

// File: tb/tb_aw_channel.sv
// Bench for aw_channel: modelled source FIFOs, scoreboard of popped descriptors,
// a vector table of single transactions and sequences for arbitration/limits.
`timescale 1ns/1ps
module tb_aw_channel;
    localparam int NS   = 8;
    localparam int DW   = 97;
    localparam int MAXO = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NS-1:0]   req_fifo_empty;
    logic [NS*DW-1:0] req_fifo_rdata;
    logic [NS-1:0]   rd_req_fifo;
    logic            awvalid, awready;
    logic [63:0]     awaddr;
    logic [7:0]      awlen, awid;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            axi_conv_fifo_full, wr_axi_conv_fifo;
    logic [DW-1:0]   axi_conv_fifo_wrdata;
    logic            bvalid, bready, illegal_size;
    logic [3:0]      outstanding_cnt;

    aw_channel #(.NUM_SRC(NS), .DESC_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_fifo_empty(req_fifo_empty), .req_fifo_rdata(req_fifo_rdata),
        .rd_req_fifo(rd_req_fifo),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awid(awid),
        .axi_conv_fifo_full(axi_conv_fifo_full), .wr_axi_conv_fifo(wr_axi_conv_fifo),
        .axi_conv_fifo_wrdata(axi_conv_fifo_wrdata),
        .bvalid(bvalid), .bready(bready),
        .illegal_size(illegal_size), .outstanding_cnt(outstanding_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    src;
        logic [DW-1:0] desc;
        logic [3:0]    delay;
        logic          illegal;
        logic          full_hold;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] src_q [NS][$];
    logic [DW-1:0] exp_q [$];
    int            grant_log [$];
    logic [3:0]    m_cnt;
    logic          m_aw_pend, m_drop_pend;
    logic [NS-1:0] s_grant;
    logic          s_awvalid, s_push, s_illegal;
    logic [3:0]    s_cnt;
    vec_t          vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] mk_desc(input logic [11:0] rsvd, input logic [7:0] id,
                                               input logic [1:0] burst, input logic [2:0] size,
                                               input logic [7:0] len, input logic [63:0] addr);
        return {rsvd, id, burst, size, len, addr};
    endfunction

    function automatic bit bench_idle();
        bit idle = (exp_q.size() == 0) && !m_aw_pend && !m_drop_pend;
        for (int n = 0; n < NS; n++) idle = idle && (src_q[n].size() == 0);
        return idle;
    endfunction

    task automatic refresh();
        for (int n = 0; n < NS; n++) begin
            req_fifo_empty[n] = (src_q[n].size() == 0);
            if (src_q[n].size() == 0) req_fifo_rdata[n*DW +: DW] = '0;
            else                      req_fifo_rdata[n*DW +: DW] = src_q[n][0];
        end
    endtask

    // One clock: sample/check before the edge, then apply FIFO pops after it.
    task automatic cycle();
        logic [DW-1:0] d;
        logic hs, bdec;
        refresh();
        #1;
        s_grant = rd_req_fifo; s_awvalid = awvalid; s_push = wr_axi_conv_fifo;
        s_illegal = illegal_size; s_cnt = outstanding_cnt;
        if (reset_n) begin
            hs = awvalid & awready;
            chk("grant_onehot", {127'd0, $onehot0(rd_req_fifo)}, 128'd1);
            chk("pop_nonempty", rd_req_fifo & req_fifo_empty, 128'd0);
            chk("cnt_model", outstanding_cnt, m_cnt);
            chk("awvalid_model", awvalid, m_aw_pend);
            chk("illegal_model", illegal_size, m_drop_pend);
            chk("push_is_hs", wr_axi_conv_fifo, hs);
            if (awvalid) begin
                if (exp_q.size() == 0) begin
                    chk("aw_exp_avail", 128'd0, 128'd1);
                end else begin
                    d = exp_q[0];
                    chk("awaddr", awaddr, d[63:0]);
                    chk("awlen", awlen, d[71:64]);
                    chk("awsize", awsize, d[74:72]);
                    chk("awburst", awburst, d[76:75]);
                    chk("awid", awid, d[84:77]);
                    if (hs) begin
                        chk("wrdata", axi_conv_fifo_wrdata, d);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (illegal_size) begin
                if (exp_q.size() == 0) begin
                    chk("drop_exp_avail", 128'd0, 128'd1);
                end else begin
                    d = exp_q.pop_front();
                    chk("drop_size", d[74:72], 128'd7);
                end
            end
            bdec = bvalid & bready & (m_cnt != 4'd0);
            if (hs && !bdec && m_cnt < 4'(MAXO)) m_cnt = m_cnt + 4'd1;
            else if (!hs && bdec)                m_cnt = m_cnt - 4'd1;
            if (hs) m_aw_pend = 1'b0;
            m_drop_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        if (reset_n) begin
            for (int n = 0; n < NS; n++) begin
                if (s_grant[n] && src_q[n].size() > 0) begin
                    d = src_q[n].pop_front();
                    exp_q.push_back(d);
                    grant_log.push_back(n);
                    if (d[74:72] <= 3'd6) m_aw_pend = 1'b1;
                    else                  m_drop_pend = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_awvalid", awvalid, 128'd0);
        chk("rst_aw_fields", {awaddr, awlen, awsize, awburst, awid}, 128'd0);
        chk("rst_rd_req", rd_req_fifo, 128'd0);
        chk("rst_push", wr_axi_conv_fifo, 128'd0);
        chk("rst_illegal", illegal_size, 128'd0);
        chk("rst_cnt", outstanding_cnt, 128'd0);
        for (int n = 0; n < NS; n++) src_q[n].delete();
        exp_q.delete();
        m_cnt = 4'd0; m_aw_pend = 1'b0; m_drop_pend = 1'b0;
        repeat (2) cycle();
        reset_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        src_q[v.src].push_back(v.desc);
        awready = (v.delay == 4'd0); bvalid = 1'b0; bready = 1'b0;
        cycle();
        chk("vec_grant", s_grant, 8'd1 << v.src);
        chk("vec_no_aw_at_grant", s_awvalid, 128'd0);
        if (!v.illegal) begin
            axi_conv_fifo_full = v.full_hold;
            for (int d = 0; d < int'(v.delay); d++) begin
                cycle();
                chk("vec_hold_valid", s_awvalid, 128'd1);
                chk("vec_hold_nopush", s_push, 128'd0);
            end
            awready = 1'b1;
            cycle();
            chk("vec_hs_valid", s_awvalid, 128'd1);
            chk("vec_push", s_push, 128'd1);
            awready = 1'b0; axi_conv_fifo_full = 1'b0; bvalid = 1'b1; bready = 1'b1;
            cycle();
            chk("vec_cnt_one", s_cnt, 128'd1);
            chk("vec_idle_after", s_awvalid, 128'd0);
            bvalid = 1'b0; bready = 1'b0;
            cycle();
            chk("vec_cnt_retired", s_cnt, 128'd0);
        end else begin
            cycle();
            chk("drop_pulse", s_illegal, 128'd1);
            chk("drop_no_awvalid", s_awvalid, 128'd0);
            chk("drop_no_push", s_push, 128'd0);
            chk("drop_cnt", s_cnt, 128'd0);
            cycle();
            chk("drop_pulse_end", s_illegal, 128'd0);
            chk("drop_still_no_aw", s_awvalid, 128'd0);
        end
    endtask

    initial begin
        int exp_arb [4];
        int ng;
        reset_n = 1'b0; awready = 1'b0; bvalid = 1'b0; bready = 1'b0;
        axi_conv_fifo_full = 1'b0;
        m_cnt = 4'd0; m_aw_pend = 1'b0; m_drop_pend = 1'b0;
        vecs[0] = '{src: 4'd3, desc: mk_desc(12'h000, 8'h03, 2'b01, 3'd6, 8'd3, 64'h1000),
                    delay: 4'd0, illegal: 1'b0, full_hold: 1'b0};
        vecs[1] = '{src: 4'd1, desc: mk_desc(12'h000, 8'hA5, 2'b10, 3'd0, 8'hFF, 64'hFFFF_FFFF_FFFF_F000),
                    delay: 4'd5, illegal: 1'b0, full_hold: 1'b0};
        vecs[2] = '{src: 4'd7, desc: mk_desc(12'hABC, 8'hFF, 2'b00, 3'd2, 8'h00, 64'h0123_4567_89AB_CDE0),
                    delay: 4'd1, illegal: 1'b0, full_hold: 1'b0};
        vecs[3] = '{src: 4'd0, desc: mk_desc(12'h000, 8'h11, 2'b01, 3'd7, 8'd1, 64'h2000),
                    delay: 4'd0, illegal: 1'b1, full_hold: 1'b0};
        vecs[4] = '{src: 4'd4, desc: mk_desc(12'h5A5, 8'h42, 2'b01, 3'd5, 8'd7, 64'h8000_0000),
                    delay: 4'd2, illegal: 1'b0, full_hold: 1'b1};
        vecs[5] = '{src: 4'd6, desc: mk_desc(12'h000, 8'h66, 2'b01, 3'd7, 8'd0, 64'h40),
                    delay: 4'd0, illegal: 1'b1, full_hold: 1'b0};

        // A pending request while in reset must not be popped.
        src_q[5].push_back(mk_desc(12'h000, 8'h01, 2'b01, 3'd0, 8'd0, 64'h0));
        refresh();
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Arbitration between two always-busy sources.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src_q[0].push_back(mk_desc(12'h000, 8'h00, 2'b01, 3'd0, 8'd0, 64'h100 + 64'(i)));
            src_q[5].push_back(mk_desc(12'h000, 8'h05, 2'b01, 3'd0, 8'd0, 64'h500 + 64'(i)));
        end
`ifdef AW_ROUND_ROBIN_EN
        exp_arb = '{0, 5, 0, 5};
`else
        exp_arb = '{0, 0, 0, 0};
`endif
        grant_log.delete();
        awready = 1'b1; bvalid = 1'b1; bready = 1'b1;
        for (int i = 0; i < 40 && grant_log.size() < 4; i++) cycle();
        chk("arb_grants_seen", {127'd0, grant_log.size() >= 4}, 128'd1);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("arb_order", grant_log[i], exp_arb[i]);
        for (int i = 0; i < 60 && !bench_idle(); i++) cycle();
        chk("arb_drained", {127'd0, bench_idle()}, 128'd1);
        repeat (3) cycle();
        bvalid = 1'b0; bready = 1'b0; awready = 1'b0;

        // Reset during ISSUE abandons the descriptor without re-popping it.
        src_q[2].push_back(mk_desc(12'h000, 8'h22, 2'b01, 3'd1, 8'd2, 64'h3000));
        cycle();
        chk("midrst_grant", s_grant, 128'h04);
        cycle();
        chk("midrst_valid", s_awvalid, 128'd1);
        do_reset();
        awready = 1'b1;
        ng = 0;
        repeat (4) begin
            cycle();
            ng += (s_grant != '0) ? 1 : 0;
            chk("midrst_no_aw", s_awvalid, 128'd0);
        end
        chk("midrst_no_repop", ng, 128'd0);

        // Outstanding limit blocks the third grant until a B beat retires one.
        for (int i = 0; i < 3; i++)
            src_q[2].push_back(mk_desc(12'h000, 8'h20, 2'b01, 3'd0, 8'd0, 64'h4000 + 64'(i)));
        for (int i = 0; i < 20 && !(m_cnt == 4'd2 && exp_q.size() == 0 && !m_aw_pend); i++) cycle();
        chk("max_reached", m_cnt, 128'd2);
        repeat (5) begin
            cycle();
            chk("max_block", s_grant, 128'd0);
        end
        bvalid = 1'b1; bready = 1'b1;
        cycle();
        bvalid = 1'b0; bready = 1'b0;
        cycle();
        chk("max_regrant", s_grant, 128'h04);
        cycle();
        cycle();
        chk("max_cnt_back", s_cnt, 128'd2);
        bvalid = 1'b1; bready = 1'b1;
        repeat (4) cycle();
        cycle();
        chk("stray_b_ignored", s_cnt, 128'd0);
        bvalid = 1'b0; bready = 1'b0;

        // W-FIFO full holds off the grant until it deasserts.
        axi_conv_fifo_full = 1'b1;
        src_q[4].push_back(mk_desc(12'h000, 8'h44, 2'b01, 3'd3, 8'd1, 64'h5000));
        repeat (4) begin
            cycle();
            chk("full_no_pop", s_grant, 128'd0);
        end
        axi_conv_fifo_full = 1'b0;
        cycle();
        chk("full_release_grant", s_grant, 128'h10);
        cycle();
        chk("full_release_push", s_push, 128'd1);
        awready = 1'b0;
        repeat (2) cycle();
        chk("final_idle", {127'd0, bench_idle()}, 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aw_channel.md
AW_CHANNEL -- requirements
Module: aw_channel

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of request sources.
REQ-002 SHALL have parameter DESC_W, default 97, descriptor width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 8, maximum in-flight write bursts (1..15).
REQ-004 SHALL have port clk, input, 1, single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_fifo_empty, input, NUM_SRC, per-source show-ahead request FIFO empty.
REQ-007 SHALL have port req_fifo_rdata, input, NUM_SRC*DESC_W, per-source head descriptor; source n occupies slice n.
REQ-008 SHALL have port rd_req_fifo, output, NUM_SRC, one-cycle pop strobe per source.
REQ-009 SHALL have ports awvalid (output, 1), awready (input, 1), awaddr (output, 64), awlen (output, 8), awsize (output, 3), awburst (output, 2), awid (output, 8): AXI write-address channel.
REQ-010 SHALL have port axi_conv_fifo_full, input, 1, W-channel command FIFO full.
REQ-011 SHALL have port wr_axi_conv_fifo, output, 1, push strobe to the W-channel command FIFO.
REQ-012 SHALL have port axi_conv_fifo_wrdata, output, DESC_W, accepted descriptor for the W channel.
REQ-013 SHALL have ports bvalid (input, 1), bready (input, 1): observed B handshake, used for retirement.
REQ-014 SHALL have port illegal_size, output, 1, one-cycle pulse when a descriptor is dropped.
REQ-015 SHALL have port outstanding_cnt, output, 4, current in-flight burst count.

Function
REQ-016 SHALL decode the descriptor as addr[63:0], len[71:64], size[74:72], burst[76:75], id[84:77]; bits [96:85] are reserved and passed through.
REQ-017 SHALL implement the states IDLE, ISSUE, and DROP.
REQ-018 SHALL grant in IDLE only when: at least one source is non-empty, axi_conv_fifo_full=0, and outstanding_cnt<MAX_OUTSTANDING.
REQ-019 SHALL, on grant, pulse rd_req_fifo for the granted source, register its descriptor, and move to ISSUE (size<=6) or DROP (size>6).
REQ-020 SHALL, in ISSUE, hold awvalid=1 with all aw* fields stable from the registered descriptor until awvalid&awready.
REQ-021 SHALL, in the awready cycle, pulse wr_axi_conv_fifo with the registered descriptor and return to IDLE; IDLE-to-grant-to-awvalid latency is 1 cycle.
REQ-022 SHALL, in DROP, pulse illegal_size for 1 cycle, issue no AW beat and no push, and return to IDLE.
REQ-023 SHALL never assert more than one rd_req_fifo bit per cycle, and never pop an empty source.
REQ-024 SHALL increment outstanding_cnt on awvalid&awready and decrement it on bvalid&bready; both in the same cycle leave it unchanged.
REQ-025 SHALL not decrement outstanding_cnt when it is 0 (a stray B beat is ignored).
REQ-026 SHALL not wrap outstanding_cnt past MAX_OUTSTANDING.
REQ-027 SHALL ignore a change in axi_conv_fifo_full while in ISSUE: space was reserved at grant, because this block is the FIFO's sole writer.

Reset
REQ-028 SHALL, on reset_n low, asynchronously force state=IDLE, awvalid=0, aw*=0, rd_req_fifo=0, wr_axi_conv_fifo=0, illegal_size=0, outstanding_cnt=0, and round-robin pointer=0.
REQ-029 SHALL, if reset occurs mid-ISSUE, abandon the registered descriptor; it is not re-popped.

Configuration
REQ-030 SHALL, with AW_ROUND_ROBIN_EN defined, arbitrate round-robin: search starts at the source after the last granted one, and the pointer updates on grant only.
REQ-031 SHALL, without AW_ROUND_ROBIN_EN, use fixed priority with source 0 highest, matching the W-channel service order.

Structure
REQ-032 SHALL place the descriptor field offsets/widths, DESC_W, the state encoding, and AXI_MAX_SIZE=6 in the shared package axi_codes_pkg.
REQ-033 SHALL implement arbitration in one sub-module, aw_arbiter (request vector in; one-hot grant and index out; pointer internal).

Verification
REQ-034 SHALL cover: source 3 holds addr=0x1000, len=3, size=6, id=3; awready=1 -> awvalid one cycle after grant, awaddr=0x1000, awlen=3, one push, outstanding_cnt=1.
REQ-035 SHALL cover: awready held low 5 cycles -> awvalid and fields stable 5 cycles, no push until the handshake.
REQ-036 SHALL cover: sources 0 and 5 continuously non-empty with RR enabled -> grants alternate 0,5,0,5; with RR disabled -> source 0 only.
REQ-037 SHALL cover: MAX_OUTSTANDING=2, no B beats -> third request not granted; one bvalid&bready -> granted next cycle.
REQ-038 SHALL cover: size=7 descriptor -> popped, illegal_size pulses once, no awvalid, no push, outstanding_cnt unchanged.
REQ-039 SHALL cover: axi_conv_fifo_full=1 with a pending request -> no pop; full deasserts -> grant the following cycle.
